// File: rtl/mem_stage.sv
// Memory stage: non-memory ops pass straight to writeback; loads/stores run one
// request/ack transaction. Optional MEM_ALIGN_CHECK_EN faults misaligned addresses.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid_i,
  input  logic [3:0]  M_icode_i,
  input  logic [31:0] M_valE_i,
  input  logic [31:0] M_valA_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [3:0]  M_dstM_i,
  output logic        m_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        m_valid_o,
  output logic [31:0] m_valE_o,
  output logic [31:0] m_valM_o,
  output logic [3:0]  m_dstE_o,
  output logic [3:0]  m_dstM_o,
  output logic [2:0]  m_stat_o,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        in_rd, in_wr, in_mem, in_misalign;
  logic [31:0] in_addr;
  logic        take_nonmem, take_mem, take_bad, finish;

  // Latched copy of the instruction under memory access
  logic [31:0] lat_valE;
  logic [3:0]  lat_dstE, lat_dstM;
  logic        lat_rd;

  assign in_rd   = (M_icode_i == I_MRMOVL) || (M_icode_i == I_POPL) || (M_icode_i == I_RET);
  assign in_wr   = (M_icode_i == I_RMMOVL) || (M_icode_i == I_PUSHL) || (M_icode_i == I_CALL);
  assign in_mem  = in_rd || in_wr;
  // Stack pops read through the old stack pointer carried in valA
  assign in_addr = ((M_icode_i == I_POPL) || (M_icode_i == I_RET)) ? M_valA_i : M_valE_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misalign = |in_addr[1:0];
`else
  assign in_misalign = 1'b0;
`endif

  assign m_stall_o = (state_q == ST_ACCESS) ||
                     ((state_q == ST_IDLE) && M_valid_i && in_mem);
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    take_nonmem = 1'b0;
    take_mem    = 1'b0;
    take_bad    = 1'b0;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (M_valid_i) begin
          if (!in_mem) begin
            take_nonmem = 1'b1;
            if (M_icode_i == I_HALT) state_d = ST_HALTED;
          end else if (in_misalign) begin
            take_bad = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            take_mem = 1'b1;
            state_d  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack_i) begin
          finish  = 1'b1;
          state_d = mem_err_i ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      lat_valE    <= '0;
      lat_dstE    <= '0;
      lat_dstM    <= '0;
      lat_rd      <= 1'b0;
      m_valid_o   <= 1'b0;
      m_valE_o    <= '0;
      m_valM_o    <= '0;
      m_dstE_o    <= '0;
      m_dstM_o    <= '0;
      m_stat_o    <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_o <= 1'b0;
      if (take_nonmem || take_bad) begin
        m_valid_o <= 1'b1;
        m_valE_o  <= M_valE_i;
        m_valM_o  <= '0;
        m_dstE_o  <= M_dstE_i;
        m_dstM_o  <= M_dstM_i;
        if (take_bad)                    m_stat_o <= S_ADR;
        else if (M_icode_i == I_HALT)    m_stat_o <= S_HLT;
        else                             m_stat_o <= S_AOK;
      end
      if (take_mem) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= in_wr;
        mem_addr_o  <= in_addr;
        mem_wdata_o <= M_valA_i;
        lat_valE    <= M_valE_i;
        lat_dstE    <= M_dstE_i;
        lat_dstM    <= M_dstM_i;
        lat_rd      <= in_rd;
      end
      if (finish) begin
        mem_req_o <= 1'b0;
        m_valid_o <= 1'b1;
        m_valE_o  <= lat_valE;
        m_valM_o  <= (lat_rd && !mem_err_i) ? mem_rdata_i : '0;
        m_dstE_o  <= lat_dstE;
        m_dstM_o  <= lat_dstM;
        m_stat_o  <= mem_err_i ? S_ADR : S_AOK;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: an instruction-level model predicts each
// writeback record and the memory request; a negedge process checks every pulse.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid_i;
  logic [3:0]  M_icode_i;
  logic [31:0] M_valE_i, M_valA_i;
  logic [3:0]  M_dstE_i, M_dstM_i;
  logic        m_stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        m_valid_o;
  logic [31:0] m_valE_o, m_valM_o;
  logic [3:0]  m_dstE_o, m_dstM_o;
  logic [2:0]  m_stat_o;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [74:0] exp_q[$];
  bit halted = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .M_valid_i(M_valid_i), .M_icode_i(M_icode_i), .M_valE_i(M_valE_i),
    .M_valA_i(M_valA_i), .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i),
    .m_stall_o(m_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .m_valid_o(m_valid_o), .m_valE_o(m_valE_o), .m_valM_o(m_valM_o),
    .m_dstE_o(m_dstE_o), .m_dstM_o(m_dstM_o), .m_stat_o(m_stat_o),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [74:0] wb(input logic [2:0] stat, input logic [3:0] dstM,
                                     input logic [3:0] dstE, input logic [31:0] valM,
                                     input logic [31:0] valE);
    return {stat, dstM, dstE, valM, valE};
  endfunction

  // Every writeback pulse must match the oldest prediction
  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_spurious actual=valid expected=no_pulse");
      end else begin
        logic [74:0] e, a;
        e = exp_q.pop_front();
        a = {m_stat_o, m_dstM_o, m_dstE_o, m_valM_o, m_valE_o};
        if (a !== e) begin
          failures++;
          $display("FAIL wb_record actual=%0h expected=%0h", a, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] icode, input logic [31:0] valE,
                       input logic [31:0] valA, input logic [3:0] dstE, input logic [3:0] dstM);
    M_valid_i = v; M_icode_i = icode; M_valE_i = valE;
    M_valA_i = valA; M_dstE_i = dstE; M_dstM_i = dstM;
  endtask

  task automatic run_op(input logic [3:0] icode, input logic [31:0] valE, input logic [31:0] valA,
                        input logic [3:0] dstE, input logic [3:0] dstM, input int waits,
                        input logic [31:0] rdata, input logic err);
    logic rd, wr, mem, bad;
    logic [31:0] addr;
    rd   = icode inside {4'h5, 4'hB, 4'h9};
    wr   = icode inside {4'h4, 4'hA, 4'h8};
    mem  = rd | wr;
    addr = (icode == 4'hB || icode == 4'h9) ? valA : valE;
    bad  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    bad  = mem && (addr[1:0] != 2'b00);
`endif
    @(posedge clk); #1;
    drive(1'b1, icode, valE, valA, dstE, dstM);
    if (halted) begin
      @(negedge clk);
      chk("halted_stall", 32'(m_stall_o), 0);
      @(posedge clk); #1;
      M_valid_i = 1'b0;
      @(negedge clk);
      chk("halted_valid", 32'(m_valid_o), 0);
      chk("halted_req", 32'(mem_req_o), 0);
    end else if (!mem || bad) begin
      exp_q.push_back(wb(bad ? 3'd3 : (icode == 4'h0 ? 3'd2 : 3'd1), dstM, dstE, 32'h0, valE));
      if (bad || icode == 4'h0) halted = 1'b1;
      @(negedge clk);
      chk("direct_stall", 32'(m_stall_o), 32'(mem));
      @(posedge clk); #1;
      M_valid_i = 1'b0;
      @(negedge clk);
      chk("direct_valid", 32'(m_valid_o), 1);
      chk("direct_noreq", 32'(mem_req_o), 0);
    end else begin
      exp_q.push_back(wb(err ? 3'd3 : 3'd1, dstM, dstE, (rd && !err) ? rdata : 32'h0, valE));
      if (err) halted = 1'b1;
      @(negedge clk);
      chk("accept_stall", 32'(m_stall_o), 1);
      chk("accept_noreq_yet", 32'(mem_req_o), 0);
      @(posedge clk); #1;
      M_valid_i = 1'b0;
      for (int w = 0; w <= waits; w++) begin
        if (w == waits) begin
          mem_ack_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
        end
        @(negedge clk);
        chk("req_held", 32'(mem_req_o), 1);
        chk("req_we", 32'(mem_we_o), 32'(wr));
        chk("req_addr", mem_addr_o, addr);
        if (wr) chk("req_wdata", mem_wdata_o, valA);
        chk("access_stall", 32'(m_stall_o), 1);
        chk("access_novalid", 32'(m_valid_o), 0);
        @(posedge clk); #1;
      end
      mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
      @(negedge clk);
      chk("done_valid", 32'(m_valid_o), 1);
      chk("done_req_drop", 32'(mem_req_o), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    halted = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_valE", m_valE_o, 0);
    chk("rst_valM", m_valM_o, 0);
    chk("rst_dst", {24'h0, m_dstE_o, m_dstM_o}, 0);
    chk("rst_stat", 32'(m_stat_o), 0);
    chk("rst_stall", 32'(m_stall_o), 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // OPL passes straight through
    run_op(4'h6, 32'h0000_0010, 32'h7, 4'h2, 4'hF, 0, 32'h0, 1'b0);
    chk("opl_valE_lit", m_valE_o, 32'h10);
    chk("opl_stat_lit", 32'(m_stat_o), 1);

    run_op(4'h5, 32'h100, 32'h0, 4'hF, 4'h3, 3, 32'hDEADBEEF, 1'b0);
    chk("mrmovl_valM_lit", m_valM_o, 32'hDEADBEEF);

    run_op(4'hA, 32'h1FC, 32'h55, 4'h4, 4'hF, 0, 32'h0, 1'b0);
    chk("pushl_valM_lit", m_valM_o, 32'h0);

    run_op(4'hB, 32'h200, 32'h1FC, 4'h4, 4'h1, 1, 32'h55, 1'b0);
    chk("popl_valM_lit", m_valM_o, 32'h55);
    chk("popl_valE_lit", m_valE_o, 32'h200);

    run_op(4'h8, 32'h2FC, 32'h42, 4'h4, 4'hF, 2, 32'h0, 1'b0);
    run_op(4'h9, 32'h304, 32'h2FC, 4'h4, 4'hF, 0, 32'h1234, 1'b0);
    run_op(4'h2, 32'hFFFF_FFFF, 32'h1, 4'h6, 4'hF, 0, 32'h0, 1'b0);

    // Ack while idle must not produce anything
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("stray_ack_valid", 32'(m_valid_o), 0);
    chk("stray_ack_req", 32'(mem_req_o), 0);

    // Misaligned load: faults only with the alignment check built in
    run_op(4'h5, 32'h102, 32'h0, 4'hF, 4'h5, 0, 32'hCAFEF00D, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_stat_lit", 32'(m_stat_o), 3);
`else
    chk("misalign_valM_lit", m_valM_o, 32'hCAFEF00D);
`endif

    do_reset();
    run_op(4'h0, 32'h0, 32'h0, 4'hF, 4'hF, 0, 32'h0, 1'b0);
    chk("halt_stat_lit", 32'(m_stat_o), 2);
    run_op(4'h6, 32'h11, 32'h0, 4'h1, 4'hF, 0, 32'h0, 1'b0);
    run_op(4'h5, 32'h100, 32'h0, 4'hF, 4'h1, 0, 32'h1, 1'b0);

    do_reset();
    run_op(4'h4, 32'h80, 32'h99, 4'hF, 4'hF, 1, 32'h0, 1'b1);
    chk("err_stat_lit", 32'(m_stat_o), 3);
    chk("err_valM_lit", m_valM_o, 0);
    run_op(4'h6, 32'h20, 32'h0, 4'h1, 4'hF, 0, 32'h0, 1'b0);

    do_reset();
    // Reset mid-access abandons the transaction; a late ack is ignored
    @(posedge clk); #1;
    drive(1'b1, 4'h5, 32'h400, 32'h0, 4'hF, 4'h2);
    @(posedge clk); #1;
    M_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_access_req", 32'(mem_req_o), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req_o), 0);
    chk("async_rst_stat", 32'(m_stat_o), 0);
    chk("async_rst_stall", 32'(m_stall_o), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_valid", 32'(m_valid_o), 0);
      chk("late_ack_req", 32'(mem_req_o), 0);
    end

    run_op(4'h6, 32'h30, 32'h0, 4'h3, 4'hF, 0, 32'h0, 1'b0);
    chk("recover_valE_lit", m_valE_o, 32'h30);

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 M_valid_i  in  1  instruction present at stage input; M_icode_i, M_valE_i, M_valA_i, M_dstE_i and M_dstM_i qualified by it.
REQ-004 M_icode_i  in  4, M_valE_i  in  32, M_valA_i  in  32, M_dstE_i  in  4, M_dstM_i  in  4  execute-stage results.
REQ-005 m_stall_o  out  1  upstream SHALL hold its inputs while high.
REQ-006 mem_req_o  out  1, mem_we_o  out  1, mem_addr_o  out  32, mem_wdata_o  out  32  data-memory request.
REQ-007 mem_ack_i  in  1, mem_rdata_i  in  32, mem_err_i  in  1  memory response, valid only when mem_ack_i=1.
REQ-008 m_valid_o  out  1, m_valE_o  out  32, m_valM_o  out  32, m_dstE_o  out  4, m_dstM_o  out  4, m_stat_o  out  3  registered writeback bundle.

Function
REQ-009 Icode classes SHALL be: read = MRMOVL(5), POPL(B), RET(9); write = RMMOVL(4), PUSHL(A), CALL(8); HALT(0) and all other codes are non-memory.
REQ-010 Address SHALL be M_valA_i for POPL and RET, and M_valE_i for every other memory icode; write data SHALL be M_valA_i.
REQ-011 FSM states SHALL be IDLE, ACCESS and HALTED.
REQ-012 IDLE: a valid non-memory input SHALL be accepted and appear on the outputs the next cycle with m_valid_o=1, m_valM_o=0 and m_stat_o=SAOK(1), or SHLT(2) for HALT.
REQ-013 IDLE: a valid memory input SHALL be latched; mem_req_o SHALL assert the next cycle; the FSM SHALL move to ACCESS.
REQ-014 ACCESS: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL remain stable until the cycle in which mem_ack_i=1.
REQ-015 On the ack edge: mem_req_o SHALL drop; the result SHALL be registered with m_valid_o=1; m_valM_o SHALL be mem_rdata_i for reads and 0 for writes; the FSM SHALL return to IDLE.
REQ-016 Minimum memory latency SHALL be 2 cycles from acceptance to m_valid_o; each additional wait cycle SHALL add exactly one cycle.
REQ-017 m_stall_o SHALL be combinationally high while in ACCESS, or while in IDLE with a valid memory input, and SHALL be low otherwise.
REQ-018 m_valid_o SHALL be a single-cycle pulse per instruction; with no accepted instruction it SHALL be 0.
REQ-019 m_valE_o, m_dstE_o and m_dstM_o SHALL pass through the latched input unchanged.
REQ-020 mem_err_i=1 with ack SHALL produce m_stat_o=SADR(3) and m_valM_o=0, and the FSM SHALL enter HALTED.
REQ-021 Emitting SHLT or SADR SHALL enter HALTED.
REQ-022 HALTED SHALL be sticky until reset: no input accepted, mem_req_o=0, m_valid_o=0, m_stall_o=0.
REQ-023 mem_ack_i outside ACCESS SHALL be ignored.

Reset
REQ-024 rst low SHALL force IDLE and clear all outputs to 0, including m_stat_o=0 and mem_req_o=0, regardless of state.
REQ-025 Reset during ACCESS SHALL abandon the transaction; a late mem_ack_i after reset release SHALL be ignored.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined, a memory input whose address has bits [1:0] not equal to 0 SHALL issue no request and SHALL complete the next cycle with m_stat_o=SADR, after which the FSM enters HALTED.
REQ-027 Without MEM_ALIGN_CHECK_EN, address bits are not checked and the access SHALL proceed normally.

Verification
REQ-028 OPL (icode 6), valE=0x0000_0010 -> next cycle m_valid_o=1, m_valE_o=0x10, m_stat_o=1, mem_req_o never asserted.
REQ-029 MRMOVL, valE=0x100; ack after 3 wait cycles with rdata=0xDEADBEEF -> mem_addr_o=0x100 and mem_we_o=0 held stable, m_stall_o high throughout, m_valM_o=0xDEADBEEF one cycle after ack.
REQ-030 PUSHL, valE=0x1FC, valA=0x55 -> mem_we_o=1, mem_addr_o=0x1FC, mem_wdata_o=0x55; POPL with valA=0x1FC -> read at 0x1FC.
REQ-031 RMMOVL with ack and mem_err_i=1 -> m_stat_o=3, then a following valid OPL is not accepted and m_valid_o stays 0.
REQ-032 rst low in ACCESS, then a stray ack after release -> mem_req_o=0, no m_valid_o pulse.
REQ-033 MEM_ALIGN_CHECK_EN defined, MRMOVL valE=0x102 -> no mem_req_o, m_stat_o=3 next cycle; undefined -> read at 0x102.
